// File: rtl/mem_arbiter.sv
// Two-master (CPU/DMA) arbiter in front of a single-ported memory.
// Fair alternation on ties, latched access parameters, per-access timeout abort.
module mem_arbiter #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_done,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  output logic [31:0] dma_rdata,
  output logic        dma_done,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        mem_err
);

  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic LAST_CPU = 1'b0;
  localparam logic LAST_DMA = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CPU_ACC = 2'd1,
    DMA_ACC = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_next_s;
  logic             last_grant_r;
  logic [CNT_W-1:0] cnt_r;

  logic             cpu_elig_s;
  logic             dma_elig_s;
  logic             grant_cpu_s;
  logic             grant_dma_s;
  logic             finish_s;
  logic             abort_s;
  logic             owner_dma_s;

  logic [31:0]      cpu_rdata_r;
  logic [31:0]      dma_rdata_r;
  logic             cpu_done_r;
  logic             dma_done_r;
  logic             mem_read_r;
  logic             mem_write_r;
  logic [31:0]      mem_addr_r;
  logic [31:0]      mem_wdata_r;
  logic             mem_err_r;

  // A requester in its done cycle is not eligible, so a held req is re-evaluated one cycle later.
  assign cpu_elig_s  = cpu_req & ~cpu_done_r;
  assign dma_elig_s  = dma_req & ~dma_done_r;
  assign owner_dma_s = (state_r == DMA_ACC);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state, grant and completion decode.
  always_comb begin
    state_next_s = state_r;
    grant_cpu_s  = 1'b0;
    grant_dma_s  = 1'b0;
    finish_s     = 1'b0;
    abort_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (cpu_elig_s && dma_elig_s) begin
          if (last_grant_r == LAST_DMA) begin
            grant_cpu_s = 1'b1;
          end else begin
            grant_dma_s = 1'b1;
          end
        end else if (cpu_elig_s) begin
          grant_cpu_s = 1'b1;
        end else if (dma_elig_s) begin
          grant_dma_s = 1'b1;
        end else begin
          grant_cpu_s = 1'b0;
        end
        if (grant_cpu_s) begin
          state_next_s = CPU_ACC;
        end else if (grant_dma_s) begin
          state_next_s = DMA_ACC;
        end else begin
          state_next_s = IDLE;
        end
      end
      CPU_ACC, DMA_ACC: begin
        // A ready on the timeout edge still counts as a normal completion.
        if (mem_ready) begin
          finish_s     = 1'b1;
          state_next_s = IDLE;
        end else if (cnt_r == TIMEOUT_C) begin
          abort_s      = 1'b1;
          state_next_s = IDLE;
        end else begin
          state_next_s = state_r;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Access latching, memory strobes, wait counter, done/err pulses and read data capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_r <= LAST_DMA;
      cnt_r        <= CNT_ZERO;
      cpu_rdata_r  <= 32'd0;
      dma_rdata_r  <= 32'd0;
      cpu_done_r   <= 1'b0;
      dma_done_r   <= 1'b0;
      mem_read_r   <= 1'b0;
      mem_write_r  <= 1'b0;
      mem_addr_r   <= 32'd0;
      mem_wdata_r  <= 32'd0;
      mem_err_r    <= 1'b0;
    end else begin
      cpu_done_r <= 1'b0;
      dma_done_r <= 1'b0;
      mem_err_r  <= 1'b0;
      if (grant_cpu_s) begin
        mem_read_r  <= ~cpu_we;
        mem_write_r <= cpu_we;
        mem_addr_r  <= cpu_addr;
        mem_wdata_r <= cpu_wdata;
        cnt_r       <= CNT_ZERO;
      end else if (grant_dma_s) begin
        mem_read_r  <= ~dma_we;
        mem_write_r <= dma_we;
        mem_addr_r  <= dma_addr;
        mem_wdata_r <= dma_wdata;
        cnt_r       <= CNT_ZERO;
      end else if (finish_s || abort_s) begin
        mem_read_r  <= 1'b0;
        mem_write_r <= 1'b0;
        mem_addr_r  <= 32'd0;
        mem_wdata_r <= 32'd0;
        cnt_r       <= CNT_ZERO;
        mem_err_r   <= abort_s;
        if (owner_dma_s) begin
          dma_done_r   <= 1'b1;
          last_grant_r <= LAST_DMA;
          if (finish_s && mem_read_r) begin
            dma_rdata_r <= mem_rdata;
          end
        end else begin
          cpu_done_r   <= 1'b1;
          last_grant_r <= LAST_CPU;
          if (finish_s && mem_read_r) begin
            cpu_rdata_r <= mem_rdata;
          end
        end
      end else if (state_r != IDLE) begin
        cnt_r <= cnt_r + CNT_ONE;
      end
    end
  end

  assign cpu_rdata = cpu_rdata_r;
  assign dma_rdata = dma_rdata_r;
  assign cpu_done  = cpu_done_r;
  assign dma_done  = dma_done_r;
  assign mem_read  = mem_read_r;
  assign mem_write = mem_write_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign mem_err   = mem_err_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios followed by randomized traffic,
// all compared every cycle against a transaction-level reference model.
module tb_mem_arbiter;
  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, dma_req, dma_we, mem_ready;
  logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata, mem_rdata;
  logic [31:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata;
  logic        cpu_done, dma_done, mem_read, mem_write, mem_err;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_done(cpu_done),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata), .dma_done(dma_done),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  // Reference model: requester 0 = CPU, 1 = DMA; owner -1 means no access in flight.
  int          m_owner;
  int          m_waited;
  int          m_last;
  logic        m_we;
  logic [31:0] m_addr, m_wdata;
  logic        m_done [2];
  logic        m_err;
  logic [31:0] m_rdata [2];

  task automatic model_reset();
    m_owner = -1; m_waited = 0; m_last = 1;
    m_we = 1'b0; m_addr = 32'd0; m_wdata = 32'd0;
    m_done[0] = 1'b0; m_done[1] = 1'b0; m_err = 1'b0;
    m_rdata[0] = 32'd0; m_rdata[1] = 32'd0;
  endtask

  task automatic model_edge();
    logic        req [2];
    logic        we [2];
    logic [31:0] ad [2];
    logic [31:0] wd [2];
    logic        nd [2];
    int          pick;
    req[0] = cpu_req; we[0] = cpu_we; ad[0] = cpu_addr; wd[0] = cpu_wdata;
    req[1] = dma_req; we[1] = dma_we; ad[1] = dma_addr; wd[1] = dma_wdata;
    nd[0] = 1'b0; nd[1] = 1'b0; m_err = 1'b0; pick = -1;
    if (m_owner < 0) begin
      if (req[0] && !m_done[0] && req[1] && !m_done[1]) pick = 1 - m_last;
      else if (req[0] && !m_done[0]) pick = 0;
      else if (req[1] && !m_done[1]) pick = 1;
      if (pick >= 0) begin
        m_owner = pick; m_waited = 0;
        m_we = we[pick]; m_addr = ad[pick]; m_wdata = wd[pick];
      end
    end else if (mem_ready) begin
      nd[m_owner] = 1'b1;
      if (!m_we) m_rdata[m_owner] = mem_rdata;
      m_last = m_owner; m_owner = -1;
    end else if (m_waited == TIMEOUT) begin
      nd[m_owner] = 1'b1; m_err = 1'b1;
      m_last = m_owner; m_owner = -1;
    end else begin
      m_waited++;
    end
    m_done = nd;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    logic busy;
    busy = (m_owner >= 0);
    chk1("cpu_done", cpu_done, m_done[0]);
    chk1("dma_done", dma_done, m_done[1]);
    chk1("mem_err", mem_err, m_err);
    chk1("mem_read", mem_read, busy && !m_we);
    chk1("mem_write", mem_write, busy && m_we);
    chk32("mem_addr", mem_addr, busy ? m_addr : 32'd0);
    chk32("mem_wdata", mem_wdata, busy ? m_wdata : 32'd0);
    chk32("cpu_rdata", cpu_rdata, m_rdata[0]);
    chk32("dma_rdata", dma_rdata, m_rdata[1]);
    chk1("done_excl", cpu_done & dma_done, 1'b0);
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst) model_reset();
    else model_edge();
    #1;
    check_model();
  endtask

  initial begin
    int rd_cnt, wr_cnt, done_cnt, first_done;
    logic stable, err_at;
    logic        c [6];
    logic        d [6];
    logic [31:0] a [6];

    rst = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'd0; cpu_wdata = 32'd0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = 32'd0; dma_wdata = 32'd0;
    mem_ready = 1'b0; mem_rdata = 32'd0;
    model_reset();
    cycle();
    cycle();
    chk1("rst_mem_read", mem_read, 1'b0);
    chk32("rst_cpu_rdata", cpu_rdata, 32'd0);
    rst = 1'b0;
    cycle();

    // CPU read alone with immediate ready.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
    mem_ready = 1'b1; mem_rdata = 32'hA5A5A5A5; rd_cnt = 0;
    cycle();
    if (mem_read) rd_cnt++;
    chk32("r19_addr", mem_addr, 32'h10);
    chk1("r19_done_early", cpu_done, 1'b0);
    cpu_req = 1'b0;
    cycle();
    if (mem_read) rd_cnt++;
    chk1("r19_done", cpu_done, 1'b1);
    chk32("r19_rdata", cpu_rdata, 32'hA5A5A5A5);
    cycle();
    if (mem_read) rd_cnt++;
    chk1("r19_pulse", cpu_done, 1'b0);
    chk32("r19_read_cycles", 32'(rd_cnt), 32'd1);

    // Simultaneous requests after reset: CPU, DMA, CPU.
    rst = 1'b1; model_reset();
    cycle();
    rst = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h100;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h200;
    mem_ready = 1'b1; mem_rdata = 32'hCAFE0001;
    for (int i = 0; i < 6; i++) begin
      cycle();
      c[i] = cpu_done; d[i] = dma_done; a[i] = mem_addr;
    end
    chk32("r20_first", a[0], 32'h100);
    chk1("r20_cpu_done", c[1], 1'b1);
    chk32("r20_second", a[2], 32'h200);
    chk1("r20_dma_done", d[3], 1'b1);
    chk32("r20_third", a[4], 32'h100);
    chk1("r20_cpu_again", c[5], 1'b1);
    cpu_req = 1'b0; dma_req = 1'b0; mem_ready = 1'b0;
    cycle();
    cycle();

    // DMA write with three wait cycles; requester inputs scrambled mid-access.
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h40; dma_wdata = 32'h1234;
    wr_cnt = 0; done_cnt = 0; stable = 1'b1;
    cycle();
    if (mem_write) wr_cnt++;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = 32'hDEADBEEF; dma_wdata = 32'h5555;
    for (int i = 0; i < 5; i++) begin
      mem_ready = (i == 3);
      cycle();
      if (mem_write) begin
        wr_cnt++;
        if (mem_addr !== 32'h40 || mem_wdata !== 32'h1234) stable = 1'b0;
      end
      if (dma_done) done_cnt++;
    end
    chk32("r21_write_cycles", 32'(wr_cnt), 32'd4);
    chk1("r21_stable", stable, 1'b1);
    chk32("r21_done_count", 32'(done_cnt), 32'd1);
    chk32("r21_rdata_kept", dma_rdata, 32'hCAFE0001);

    // Timeout on a CPU read with DMA pending.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h80;
    mem_ready = 1'b0; mem_rdata = 32'h0BAD0BAD;
    cycle();
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h300;
    first_done = -1; err_at = 1'b0;
    for (int i = 1; i <= 20 && first_done < 0; i++) begin
      cycle();
      if (cpu_done) begin
        first_done = i; err_at = mem_err;
      end
    end
    chk32("r22_abort_cycle", 32'(first_done), 32'd16);
    chk1("r22_err", err_at, 1'b1);
    chk32("r22_rdata_kept", cpu_rdata, 32'hCAFE0001);
    cycle();
    chk32("r22_dma_granted", mem_addr, 32'h300);
    cpu_req = 1'b0; dma_req = 1'b0; mem_ready = 1'b1;
    cycle();
    mem_ready = 1'b0;
    cycle();

    // Asynchronous reset during a DMA access, CPU pending.
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h500; dma_wdata = 32'h77;
    cycle();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h600;
    cycle();
    chk1("r23_in_access", mem_write, 1'b1);
    #2;
    rst = 1'b1; model_reset();
    #1;
    chk1("r23_async_write", mem_write, 1'b0);
    chk32("r23_async_addr", mem_addr, 32'd0);
    chk32("r23_async_rdata", cpu_rdata, 32'd0);
    cycle();
    rst = 1'b0;
    cycle();
    chk32("r23_cpu_first", mem_addr, 32'h600);
    chk1("r23_cpu_read", mem_read, 1'b1);
    cpu_req = 1'b0; dma_req = 1'b0; mem_ready = 1'b1;
    cycle();
    mem_ready = 1'b0;
    cycle();

    // Randomized traffic: fast memory first, then a slow one to hit timeouts.
    for (int n = 0; n < 3000; n++) begin
      cpu_req   = ($urandom_range(99, 0) < 60);
      dma_req   = ($urandom_range(99, 0) < 60);
      cpu_we    = 1'($urandom);
      dma_we    = 1'($urandom);
      cpu_addr  = $urandom; cpu_wdata = $urandom;
      dma_addr  = $urandom; dma_wdata = $urandom;
      mem_rdata = $urandom;
      mem_ready = ($urandom_range(99, 0) < ((n < 1500) ? 35 : 4));
      cycle();
      if (n % 700 == 699) begin
        #2;
        rst = 1'b1; model_reset();
        #1;
        check_model();
        cycle();
        rst = 1'b0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
